// File: rtl/i2c_config_sequencer.sv
// I2C master write sequencer: streams a constant table of register writes.
// Optional I2C_RETRY_EN re-sends a NACKed register up to MAX_RETRY times.
module i2c_config_sequencer #(
    parameter int NUM_REGS       = 10,
    parameter int BYTES_PER_XFER = 3,
    parameter int CLK_DIV        = 4,
    parameter int MAX_RETRY      = 3,
    parameter logic [NUM_REGS*BYTES_PER_XFER*8-1:0] CONFIG = 240'h0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_sdat,
    output logic       o_sclk,
    output logic       o_sdat,
    output logic       o_oen,
    output logic       o_busy,
    output logic       o_finished,
    output logic       o_error,
    output logic [7:0] o_nack_count,
    output logic [2:0] o_state
);

    localparam int TOTAL = NUM_REGS * BYTES_PER_XFER * 8;
    localparam int IW    = $clog2(TOTAL);
    localparam int RW    = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam int BW    = BYTES_PER_XFER > 1 ? $clog2(BYTES_PER_XFER) : 1;
    localparam int DW    = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        ACK   = 3'd3,
        STOP  = 3'd4,
        GAP   = 3'd5,
        ABORT = 3'd6
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [DW-1:0]  div;
    logic [1:0]     q;
    logic [1:0]     q_last;
    logic [2:0]     bit_idx;
    logic [BW-1:0]  byte_idx;
    logic [RW-1:0]  reg_idx;
    logic           nack;
    logic [7:0]     nack_count;
    logic           finished;
    logic           error;
    logic           tick;
    logic           last_q;
    logic           last_byte;
    logic           last_reg;
    logic           accept;
    logic           retry_ok;
    logic           retry_fail;
    int             flat;
    logic [IW-1:0]  bit_pos;
    logic           data_bit;

    assign tick      = (state != IDLE) && (div == DW'(CLK_DIV - 1));
    assign last_q    = tick && (q == q_last);
    assign last_byte = byte_idx == BW'(BYTES_PER_XFER - 1);
    assign last_reg  = reg_idx == RW'(NUM_REGS - 1);
    // A start coinciding with the finished pulse waits one cycle
    assign accept    = (state == IDLE) && i_start && !finished;

    always_comb begin
        flat = (int'(reg_idx) * BYTES_PER_XFER + int'(byte_idx)) * 8
             + int'(bit_idx);
        bit_pos = IW'(TOTAL - 1 - flat);
    end

    assign data_bit = CONFIG[bit_pos];

    always_comb begin
        unique case (state)
            START, GAP:  q_last = 2'd1;
            STOP, ABORT: q_last = 2'd2;
            DATA, ACK:   q_last = 2'd3;
            default:     q_last = 2'd0;
        endcase
    end

`ifdef I2C_RETRY_EN
    logic [3:0] retry_cnt;
    logic       failed;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            retry_cnt <= '0;
            failed    <= 1'b0;
        end else if (accept) begin
            retry_cnt <= '0;
            failed    <= 1'b0;
        end else if (state == ACK && last_q && nack && retry_ok) begin
            retry_cnt <= retry_cnt + 4'd1;
            failed    <= 1'b1;
        end else if (state == STOP && last_q) begin
            failed <= 1'b0;
            if (!failed)
                retry_cnt <= '0;
        end
    end

    assign retry_ok   = retry_cnt < 4'(MAX_RETRY);
    assign retry_fail = failed;
`else
    // MAX_RETRY has no effect without retries
    assign retry_ok   = (MAX_RETRY < 0);
    assign retry_fail = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        o_sclk  = 1'b1;
        o_sdat  = 1'b1;
        o_oen   = 1'b1;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_n = START;
            end
            START: begin
                o_sdat = (q == 2'd0);
                if (last_q)
                    state_n = DATA;
            end
            DATA: begin
                o_sclk = q[1];
                o_sdat = data_bit;
                if (last_q && bit_idx == 3'd7)
                    state_n = ACK;
            end
            ACK: begin
                o_sclk = q[1];
                o_oen  = 1'b0;
                if (last_q) begin
                    if (nack)
                        state_n = retry_ok ? STOP : ABORT;
                    else
                        state_n = last_byte ? STOP : DATA;
                end
            end
            STOP, ABORT: begin
                o_sclk = (q != 2'd0);
                o_sdat = (q == 2'd2);
                if (last_q) begin
                    if (state == ABORT)
                        state_n = IDLE;
                    else if (retry_fail || !last_reg)
                        state_n = GAP;
                    else
                        state_n = IDLE;
                end
            end
            GAP: begin
                if (last_q)
                    state_n = START;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div        <= '0;
            q          <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            reg_idx    <= '0;
            nack       <= 1'b0;
            nack_count <= '0;
            finished   <= 1'b0;
            error      <= 1'b0;
        end else begin
            finished <= 1'b0;
            if (state == IDLE) begin
                div <= '0;
                q   <= '0;
                if (accept) begin
                    bit_idx  <= '0;
                    byte_idx <= '0;
                    reg_idx  <= '0;
                    error    <= 1'b0;
                end
            end else begin
                div <= tick ? '0 : div + 1'b1;
                if (tick)
                    q <= last_q ? 2'd0 : q + 2'd1;
            end
            if (state == DATA && last_q)
                bit_idx <= bit_idx + 3'd1;
            if (state == ACK && tick && q == 2'd2) begin
                nack <= i_sdat;
                if (i_sdat && nack_count != 8'hFF)
                    nack_count <= nack_count + 8'd1;
            end
            if (state == ACK && last_q)
                byte_idx <= (nack || last_byte) ? '0 : byte_idx + 1'b1;
            if (state == STOP && last_q && !retry_fail) begin
                if (last_reg)
                    finished <= 1'b1;
                else
                    reg_idx <= reg_idx + 1'b1;
            end
            if (state == ABORT && last_q)
                error <= 1'b1;
        end
    end

    assign o_busy       = state != IDLE;
    assign o_finished   = finished;
    assign o_error      = error;
    assign o_nack_count = nack_count;
    assign o_state      = state;

endmodule
